ctrl_fsm_unit: RTL
==================

// Module: ctrl_fsm_unit
// PURPOSE
//  Parametrised sequencing control unit for the Beta-style datapath.
//  - Decodes OPCODE into datapath selects: PCSEL, RA2SEL, ASEL, BSEL, WDSEL, ALUFN, WR, WERF, WASEL.
//  - Adds what a pure decoder cannot: multi-cycle MUL/DIV stalls, IRQ entry at instruction boundaries, a PC-advance strobe.
//  - Sits between instruction fetch and the datapath; drives the PC mux and register-file write enables.
// PARAMETERS
//  OPC_W       6  opcode width (decode table has 2**OPC_W entries)
//  ALUFN_W     6  ALU function code width
//  MULDIV_LAT  4  execute cycles for MUL/DIV/MULC/DIVC; 1 = no stall; legal range 1..15
//  IRQ_SYNC    2  IRQ synchroniser flops, >=2
// PORTS
//  CLK          in   1        system clock, rising edge
//  RESET        in   1        asynchronous, active-high reset
//  OPCODE       in   OPC_W    current instruction opcode
//  INSTR_VALID  in   1        OPCODE holds a fetched instruction this cycle
//  Z            in   1        Ra==0 flag for BEQ/BNE
//  IRQ          in   1        asynchronous interrupt request, level
//  SUPERVISOR   in   1        PC[31]; IRQ is masked when high
//  PCSEL        out  3        0 PC+4, 1 branch, 2 JMP, 3 ILLOP, 4 XAdr
//  RA2SEL,ASEL,BSEL  out 1    datapath selects
//  WDSEL        out  2        0 PC+4, 1 ALU, 2 memory
//  ALUFN        out  ALUFN_W  ALU function
//  WR, WERF     out  1        memory write, register-file write
//  WASEL        out  1        1 = write XP (R30)
//  PC_EN        out  1        PC register load strobe
//  IRQ_ACK      out  1        one-cycle pulse when the IRQ is taken
// BEHAVIOUR
//  - FSM states: RUN, MD_WAIT, IRQ_TAKE. Regs: irq_sync[IRQ_SYNC], irq_pend, md_cnt[3:0].
//  - Reset (async): state=RUN, irq_pend=0, md_cnt=0.
//    While RESET=1, all outputs = 0; this forces WR, WERF and PC_EN low.
//  - Outputs are combinational from (state, OPCODE, Z, irq_pend, SUPERVISOR). 0-cycle decode latency in RUN.
//  - irq_pend: set when the synchronised IRQ is 1; cleared only on leaving IRQ_TAKE.
//  - RUN, !INSTR_VALID: bubble. WR=WERF=PC_EN=0, PCSEL=0; other selects don't-care, driven 0.
//  - RUN, INSTR_VALID, irq_pend && !SUPERVISOR: next state IRQ_TAKE; outputs are a bubble this cycle.
//  - IRQ_TAKE (1 cycle): PCSEL=4, WASEL=1, WDSEL=0, WERF=1, WR=0, PC_EN=1, IRQ_ACK=1. Next state RUN.
//    The interrupted instruction is not executed and replays after return.
//  - RUN, INSTR_VALID, MUL-class opcode (100010, 100011, 110010, 110011), MULDIV_LAT>1:
//    md_cnt = MULDIV_LAT-1, state MD_WAIT. Outputs: ALUFN/BSEL/ASEL decoded, WR=WERF=PC_EN=0.
//  - MD_WAIT: hold ALUFN/BSEL/ASEL; md_cnt--.
//    At md_cnt==1 emit full decode (WERF=1, PC_EN=1) and return to RUN.
//    An IRQ arriving during MD_WAIT stays pending; it is taken at the next valid instruction.
//  - Other valid opcodes: table decode, PC_EN=1.
//    BEQ: PCSEL={2'b0,Z}. BNE: PCSEL={2'b0,~Z}. Both write PC+4 to Rc (WDSEL=0, WERF=1). JMP: PCSEL=2, WERF=1.
//    ST: WR=1, WERF=0, RA2SEL=1. LD: WDSEL=2, WERF=1.
//  - RESET mid-MD_WAIT or mid-IRQ_TAKE: abort, return to RUN, drop irq_pend. No partial write escapes.
//  - The OPCODE value is ignored while in MD_WAIT. The datapath holds the instruction (PC_EN=0).
// CONFIGURATION
//  ILLOP_TRAP_EN defined: undefined opcodes trap with PCSEL=3, WASEL=1, WDSEL=0, WERF=1, PC_EN=1.
//    Undefined opcodes: 000000-010111, 011010, 011100, 100111, 101011, 101111, 110111, 111011, 111111.
//  ILLOP_TRAP_EN undefined: undefined opcodes execute as NOP (WR=WERF=0, PCSEL=0, PC_EN=1).
// STRUCTURE
//  - ctrl_pkg: opcode localparams, PCSEL encodings, WDSEL encodings, ALUFN codes,
//    FSM state encodings, decode-word field layout <ALUFN><PCSEL><RA2SEL><ASEL><BSEL><WDSEL><WR><WERF><WASEL>.
//  - Sub-module ctrl_decode_rom: combinational OPCODE -> decode word, including the illegal flag and the mul-class flag.
//  - The FSM, synchroniser and output gating stay in ctrl_fsm_unit.
// TESTING
//  1. RESET=1 with OPCODE=ST(011001) -> WR=WERF=PC_EN=0; after release, ST gives WR=1, WERF=0, PC_EN=1.
//  2. BEQ(011101) Z=1 -> PCSEL=1, WERF=1, WDSEL=0; Z=0 -> PCSEL=0; BNE Z=0 -> PCSEL=1.
//  3. MUL(100010), MULDIV_LAT=4 -> PC_EN=0, WERF=0 for 3 cycles; 4th cycle WERF=1, PC_EN=1.
//  4. IRQ=1, SUPERVISOR=0, ADD valid -> after IRQ_SYNC cycles: bubble, then PCSEL=4, WASEL=1, WERF=1, IRQ_ACK pulse.
//     Same stimulus with SUPERVISOR=1 -> no IRQ_ACK.
//  5. IRQ asserted mid-MUL wait -> MUL completes (WERF=1); IRQ taken at the next valid instruction.
//  6. OPCODE=000101 -> with ILLOP_TRAP_EN: PCSEL=3, WASEL=1; without: WERF=WR=0, PCSEL=0, PC_EN=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the Beta sequencing control unit: opcodes, select encodings,
// ALU function codes, FSM states and the decode-word layout.
package ctrl_pkg;

  localparam logic [5:0] OP_LD    = 6'b011000;
  localparam logic [5:0] OP_ST    = 6'b011001;
  localparam logic [5:0] OP_JMP   = 6'b011011;
  localparam logic [5:0] OP_BEQ   = 6'b011101;
  localparam logic [5:0] OP_BNE   = 6'b011110;
  localparam logic [5:0] OP_LDR   = 6'b011111;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100001;
  localparam logic [5:0] OP_MUL   = 6'b100010;
  localparam logic [5:0] OP_DIV   = 6'b100011;
  localparam logic [5:0] OP_CMPEQ = 6'b100100;
  localparam logic [5:0] OP_CMPLT = 6'b100101;
  localparam logic [5:0] OP_CMPLE = 6'b100110;
  localparam logic [5:0] OP_AND   = 6'b101000;
  localparam logic [5:0] OP_OR    = 6'b101001;
  localparam logic [5:0] OP_XOR   = 6'b101010;
  localparam logic [5:0] OP_SHL   = 6'b101100;
  localparam logic [5:0] OP_SHR   = 6'b101101;
  localparam logic [5:0] OP_SRA   = 6'b101110;
  localparam logic [5:0] OP_ADDC   = 6'b110000;
  localparam logic [5:0] OP_SUBC   = 6'b110001;
  localparam logic [5:0] OP_MULC   = 6'b110010;
  localparam logic [5:0] OP_DIVC   = 6'b110011;
  localparam logic [5:0] OP_CMPEQC = 6'b110100;
  localparam logic [5:0] OP_CMPLTC = 6'b110101;
  localparam logic [5:0] OP_CMPLEC = 6'b110110;
  localparam logic [5:0] OP_ANDC   = 6'b111000;
  localparam logic [5:0] OP_ORC    = 6'b111001;
  localparam logic [5:0] OP_XORC   = 6'b111010;
  localparam logic [5:0] OP_SHLC   = 6'b111100;
  localparam logic [5:0] OP_SHRC   = 6'b111101;
  localparam logic [5:0] OP_SRAC   = 6'b111110;

  localparam logic [2:0] PCSEL_PC4   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  localparam logic [1:0] WDSEL_PC4 = 2'd0;
  localparam logic [1:0] WDSEL_ALU = 2'd1;
  localparam logic [1:0] WDSEL_MEM = 2'd2;

  localparam logic [5:0] ALUFN_ADD   = 6'h00;
  localparam logic [5:0] ALUFN_SUB   = 6'h01;
  localparam logic [5:0] ALUFN_MUL   = 6'h02;
  localparam logic [5:0] ALUFN_DIV   = 6'h03;
  localparam logic [5:0] ALUFN_CMPEQ = 6'h33;
  localparam logic [5:0] ALUFN_CMPLT = 6'h37;
  localparam logic [5:0] ALUFN_CMPLE = 6'h3D;
  localparam logic [5:0] ALUFN_AND   = 6'h18;
  localparam logic [5:0] ALUFN_OR    = 6'h1E;
  localparam logic [5:0] ALUFN_XOR   = 6'h16;
  localparam logic [5:0] ALUFN_SHL   = 6'h20;
  localparam logic [5:0] ALUFN_SHR   = 6'h21;
  localparam logic [5:0] ALUFN_SRA   = 6'h23;
  localparam logic [5:0] ALUFN_A     = 6'h1A;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_IRQ_TAKE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } br_e;

  typedef struct packed {
    logic [5:0] alufn;
    logic [2:0] pcsel;
    logic       ra2sel;
    logic       asel;
    logic       bsel;
    logic [1:0] wdsel;
    logic       wr;
    logic       werf;
    logic       wasel;
  } dec_word_t;

  // Register/constant ALU ops share one shape; only BSEL picks the literal.
  function automatic dec_word_t alu_word(input logic [5:0] fn, input logic use_lit);
    dec_word_t w;
    w       = '0;
    w.alufn = fn;
    w.bsel  = use_lit;
    w.wdsel = WDSEL_ALU;
    w.werf  = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode decoder producing the static decode word plus branch/illegal/mul flags.
// ILLOP_TRAP_EN selects whether undefined opcodes trap or execute as NOP.
module ctrl_decode_rom
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output dec_word_t        word,
  output br_e              branch,
  output logic             illegal,
  output logic             mul_class
);

  logic [5:0] op6;
  logic       upper_ok;

  assign op6      = 6'(opcode);
  assign upper_ok = ((opcode >> 6) == '0);

  always_comb begin
    word      = '0;
    branch    = BR_NONE;
    illegal   = 1'b0;
    mul_class = upper_ok && (op6 inside {OP_MUL, OP_DIV, OP_MULC, OP_DIVC});
    if (!upper_ok) begin
      illegal = 1'b1;
    end else begin
      case (op6)
        OP_LD: begin
          word.alufn = ALUFN_ADD;
          word.bsel  = 1'b1;
          word.wdsel = WDSEL_MEM;
          word.werf  = 1'b1;
        end
        OP_ST: begin
          word.alufn  = ALUFN_ADD;
          word.bsel   = 1'b1;
          word.ra2sel = 1'b1;
          word.wr     = 1'b1;
        end
        OP_JMP: begin
          word.pcsel = PCSEL_JMP;
          word.wdsel = WDSEL_PC4;
          word.werf  = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          branch     = (op6 == OP_BEQ) ? BR_EQ : BR_NE;
          word.pcsel = PCSEL_BR;
          word.wdsel = WDSEL_PC4;
          word.werf  = 1'b1;
        end
        OP_LDR: begin
          word.alufn = ALUFN_A;
          word.asel  = 1'b1;
          word.wdsel = WDSEL_MEM;
          word.werf  = 1'b1;
        end
        OP_ADD,   OP_ADDC:   word = alu_word(ALUFN_ADD,   op6[4]);
        OP_SUB,   OP_SUBC:   word = alu_word(ALUFN_SUB,   op6[4]);
        OP_MUL,   OP_MULC:   word = alu_word(ALUFN_MUL,   op6[4]);
        OP_DIV,   OP_DIVC:   word = alu_word(ALUFN_DIV,   op6[4]);
        OP_CMPEQ, OP_CMPEQC: word = alu_word(ALUFN_CMPEQ, op6[4]);
        OP_CMPLT, OP_CMPLTC: word = alu_word(ALUFN_CMPLT, op6[4]);
        OP_CMPLE, OP_CMPLEC: word = alu_word(ALUFN_CMPLE, op6[4]);
        OP_AND,   OP_ANDC:   word = alu_word(ALUFN_AND,   op6[4]);
        OP_OR,    OP_ORC:    word = alu_word(ALUFN_OR,    op6[4]);
        OP_XOR,   OP_XORC:   word = alu_word(ALUFN_XOR,   op6[4]);
        OP_SHL,   OP_SHLC:   word = alu_word(ALUFN_SHL,   op6[4]);
        OP_SHR,   OP_SHRC:   word = alu_word(ALUFN_SHR,   op6[4]);
        OP_SRA,   OP_SRAC:   word = alu_word(ALUFN_SRA,   op6[4]);
        default:             illegal = 1'b1;
      endcase
    end
    if (illegal) begin
      word = '0;
`ifdef ILLOP_TRAP_EN
      word.pcsel = PCSEL_ILLOP;
      word.wasel = 1'b1;
      word.wdsel = WDSEL_PC4;
      word.werf  = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/ctrl_fsm_unit.sv
// Beta sequencing control unit: decode plus MUL/DIV stall, IRQ entry and PC-advance strobe.
// Define ILLOP_TRAP_EN to trap undefined opcodes (otherwise they run as NOP).
module ctrl_fsm_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W      = 6,
  parameter int ALUFN_W    = 6,
  parameter int MULDIV_LAT = 4,
  parameter int IRQ_SYNC   = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [OPC_W-1:0]   OPCODE,
  input  logic               INSTR_VALID,
  input  logic               Z,
  input  logic               IRQ,
  input  logic               SUPERVISOR,
  output logic [2:0]         PCSEL,
  output logic               RA2SEL,
  output logic               ASEL,
  output logic               BSEL,
  output logic [1:0]         WDSEL,
  output logic [ALUFN_W-1:0] ALUFN,
  output logic               WR,
  output logic               WERF,
  output logic               WASEL,
  output logic               PC_EN,
  output logic               IRQ_ACK
);

  localparam bit         MD_STALL  = (MULDIV_LAT > 1);
  localparam logic [3:0] MD_LAT_M1 = 4'(MULDIV_LAT - 1);

  state_e                state, state_nxt;
  logic [IRQ_SYNC-1:0]   irq_sync;
  logic                  irq_pend;
  logic [3:0]            md_cnt;
  dec_word_t             md_word;

  dec_word_t             dec_word;
  br_e                   dec_br;
  logic                  dec_illegal;
  logic                  dec_mul;
  logic                  take_irq;
  logic                  start_md;

  dec_word_t             out_word;
  logic                  out_pc_en;
  logic                  out_ack;

  ctrl_decode_rom #(.OPC_W(OPC_W)) u_rom (
    .opcode    (OPCODE),
    .word      (dec_word),
    .branch    (dec_br),
    .illegal   (dec_illegal),
    .mul_class (dec_mul)
  );

  assign take_irq = INSTR_VALID && irq_pend && !SUPERVISOR;
  assign start_md = MD_STALL && INSTR_VALID && !take_irq && dec_mul && !dec_illegal;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // The pending flag clears on the IRQ_TAKE cycle; a still-high IRQ re-arms it afterwards.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_sync <= '0;
      irq_pend <= 1'b0;
    end else begin
      irq_sync <= {irq_sync[IRQ_SYNC-2:0], IRQ};
      if (state == ST_IRQ_TAKE)         irq_pend <= 1'b0;
      else if (irq_sync[IRQ_SYNC-1])    irq_pend <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      md_cnt  <= '0;
      md_word <= '0;
    end else if (state == ST_RUN && start_md) begin
      md_cnt  <= MD_LAT_M1;
      md_word <= dec_word;
    end else if (state == ST_MD_WAIT) begin
      md_cnt  <= md_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (take_irq)      state_nxt = ST_IRQ_TAKE;
        else if (start_md) state_nxt = ST_MD_WAIT;
      end
      ST_MD_WAIT:  if (md_cnt == 4'd1) state_nxt = ST_RUN;
      ST_IRQ_TAKE: state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // Reset overrides everything so no write or PC load escapes while RESET is high.
  always_comb begin
    out_word  = '0;
    out_pc_en = 1'b0;
    out_ack   = 1'b0;
    case (state)
      ST_RUN: begin
        if (INSTR_VALID && !take_irq) begin
          out_word = dec_word;
          if (dec_br == BR_EQ)      out_word.pcsel = {2'b00, Z};
          else if (dec_br == BR_NE) out_word.pcsel = {2'b00, ~Z};
          if (start_md) begin
            out_word.wr   = 1'b0;
            out_word.werf = 1'b0;
          end else begin
            out_pc_en = 1'b1;
          end
        end
      end
      ST_MD_WAIT: begin
        out_word = md_word;
        if (md_cnt == 4'd1) begin
          out_pc_en = 1'b1;
        end else begin
          out_word.wr   = 1'b0;
          out_word.werf = 1'b0;
        end
      end
      ST_IRQ_TAKE: begin
        out_word.pcsel = PCSEL_XADR;
        out_word.wasel = 1'b1;
        out_word.wdsel = WDSEL_PC4;
        out_word.werf  = 1'b1;
        out_pc_en      = 1'b1;
        out_ack        = 1'b1;
      end
      default: ;
    endcase
    if (RESET) begin
      out_word  = '0;
      out_pc_en = 1'b0;
      out_ack   = 1'b0;
    end
  end

  assign PCSEL   = out_word.pcsel;
  assign RA2SEL  = out_word.ra2sel;
  assign ASEL    = out_word.asel;
  assign BSEL    = out_word.bsel;
  assign WDSEL   = out_word.wdsel;
  assign ALUFN   = ALUFN_W'(out_word.alufn);
  assign WR      = out_word.wr;
  assign WERF    = out_word.werf;
  assign WASEL   = out_word.wasel;
  assign PC_EN   = out_pc_en;
  assign IRQ_ACK = out_ack;

endmodule
